imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Sequencer for the 16-bit instruction memory. After reset it bootstraps the memory from a word stream (program loader). It then runs the program counter, fetches one instruction per cycle through the memory's asynchronous read port, and presents it to decode over a valid/ready handshake with a single-entry instruction register. It also handles branch/jump redirects from the datapath.

## Interface
- ADDR_WIDTH, 6, instruction memory address width (2**ADDR_WIDTH words)
- DATA_WIDTH, 16, instruction word width
- RESET_PC, 0, PC value on entry to RUN

- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- load_valid  input  1  loader word present on load_data this cycle
- load_data  input  DATA_WIDTH  loader instruction word
- load_done  input  1  loader finished; enter RUN
- mem_addr  output  ADDR_WIDTH  memory address (combinational from state)
- mem_we  output  1  memory write enable
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory async read data for mem_addr
- inst_valid  output  1  inst_out/inst_pc hold a valid instruction
- inst_ready  input  1  decode accepts instruction this cycle
- inst_out  output  DATA_WIDTH  fetched instruction
- inst_pc  output  ADDR_WIDTH  address inst_out was fetched from
- redirect_valid  input  1  branch/jump taken; refetch from redirect_pc
- redirect_pc  input  ADDR_WIDTH  redirect target
- loading  output  1  high while in LOAD
- halted  output  1  high while in HALT

## Operation
- States: LOAD, RUN, HALT. Reset → LOAD.
- LOAD:
  - load_ptr starts at 0.
  - When load_valid is high: mem_we=1, mem_addr=load_ptr, mem_wdata=load_data, and load_ptr increments. It wraps from 2**ADDR_WIDTH-1 to 0.
  - load_done → RUN with pc=RESET_PC. If load_valid and load_done are high in the same cycle, the word is written, then the state changes.
  - redirect_valid and inst_ready are ignored.
- RUN:
  - mem_addr=pc, mem_we=0.
  - A fetch occurs when !inst_valid || inst_ready. On a fetch: inst_out<=mem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+1 (wraps to 0).
  - If no fetch occurs, the register holds and pc holds (stall).
- Redirect (RUN only) has priority over fetch.
  - pc<=redirect_pc and inst_valid<=0 on that edge; no fetch that cycle.
  - A handshake (inst_valid && inst_ready) in the same cycle still counts as consumed; the registered instruction is then discarded.
- HALT (only with the configuration macro defined):
  - No fetches. inst_valid drains normally on inst_ready and then stays 0.
  - redirect_valid → RUN with pc<=redirect_pc.
- mem_wdata = load_data in all states; meaningful only when mem_we=1.
- Reset mid-operation: returns to LOAD and load_ptr=0. Memory contents are not cleared.

## Timing
- Reset values:
  - state=LOAD, load_ptr=0, pc=RESET_PC.
  - inst_valid=0, inst_out=0, inst_pc=0.
  - mem_we=0, mem_addr=0, loading=1, halted=0.
- Load write: mem_we is combinational in the same cycle as load_valid. The memory captures the word on that edge.
- First fetch: one cycle after entering RUN, i.e. mem_addr=RESET_PC in the first RUN cycle. inst_valid=1 after the next edge.
- Fetch latency: pc to inst_valid is 1 edge. Throughput is 1 instruction/cycle with inst_ready held high.
- Redirect: target instruction is valid 2 edges after the redirect_valid cycle (1 bubble).
- inst_out and inst_pc are stable while inst_valid && !inst_ready.
- loading and halted are registered state decodes.

## Configuration
- FETCH_HALT_EN defined:
  - On a fetch whose mem_rdata == all-ones (16'hFFFF), the word is delivered as a normal instruction.
  - The state then goes to HALT and pc stops at halt address + 1.
  - If redirect_valid is high in that same cycle, the redirect wins and the state stays RUN.
- FETCH_HALT_EN undefined: HALT is unreachable, halted is tied 0, and all-ones is an ordinary instruction.

## Test plan
- Load sweep: reset, then load words 0x1000..0x1003 with load_valid, then load_done. Required: mem_we pulses at addr 0..3 with the matching data, loading drops, and decode receives 0x1000@pc0, 0x1001@pc1, ... one per cycle.
- Backpressure: inst_ready low for 3 cycles mid-stream. Required: inst_out/inst_pc frozen, pc unchanged, no instruction lost or duplicated after ready returns.
- Redirect: redirect_valid with redirect_pc=0x20 while inst_valid=1 and inst_ready=1. Required: the current instruction is consumed, the next edge has inst_valid=0, the following edge has inst_pc=0x20.
- Wrap: ADDR_WIDTH=6, run from pc 62. Required: fetch order is 62, 63, 0, 1. Loading 65 words wraps the 65th write to addr 0.
- Simultaneous and reset events:
  - load_valid with load_done in one cycle: the last word is written and RUN follows.
  - reset asserted during RUN: loading=1, inst_valid=0, and the next load writes addr 0.
- FETCH_HALT_EN defined: program 0x1111 at addr 0, 0xFFFF at addr 1. Required: both delivered, then halted=1 with no further fetches, then redirect_pc=0 resumes fetching from addr 0.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: loader, memory, decode and redirect bundle; master = fetch controller, slave = memory/loader/decode side
interface imem_fetch_ctrl_if #(parameter int ADDR_WIDTH = 6, parameter int DATA_WIDTH = 16);
  logic load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic load_done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic inst_valid;
  logic inst_ready;
  logic [DATA_WIDTH-1:0] inst_out;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic loading;
  logic halted;
  modport master (
    input  load_valid, load_data, load_done, mem_rdata, inst_ready, redirect_valid, redirect_pc,
    output mem_addr, mem_we, mem_wdata, inst_valid, inst_out, inst_pc, loading, halted
  );
  modport slave (
    output load_valid, load_data, load_done, mem_rdata, inst_ready, redirect_valid, redirect_pc,
    input  mem_addr, mem_we, mem_wdata, inst_valid, inst_out, inst_pc, loading, halted
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: loads instruction memory then fetches one word per cycle to decode (ports clk, reset, bus master); FETCH_HALT_EN adds halt on an all-ones word
module imem_fetch_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  imem_fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] load_ptr;
  logic [ADDR_WIDTH-1:0] pc;
  logic fetch;
  always_comb begin
    bus.mem_addr = state == LOAD ? load_ptr : pc;
    bus.mem_we = state == LOAD && bus.load_valid;
    bus.mem_wdata = DATA_WIDTH'(bus.load_data);
    fetch = state == RUN && !bus.redirect_valid && (!bus.inst_valid || bus.inst_ready);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      load_ptr <= '0;
      pc <= RESET_PC;
      bus.inst_valid <= 1'b0;
      bus.inst_out <= '0;
      bus.inst_pc <= '0;
      bus.loading <= 1'b1;
      bus.halted <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.load_valid) load_ptr <= load_ptr + 1'b1;
          if (bus.load_done) begin
            state <= RUN;
            pc <= RESET_PC;
            bus.loading <= 1'b0;
          end
        end
        RUN: begin
          if (bus.redirect_valid) begin
            pc <= bus.redirect_pc;
            bus.inst_valid <= 1'b0;
          end else if (fetch) begin
            bus.inst_out <= bus.mem_rdata;
            bus.inst_pc <= pc;
            bus.inst_valid <= 1'b1;
            pc <= pc + 1'b1;
`ifdef FETCH_HALT_EN
            if (&bus.mem_rdata) begin
              state <= HALT;
              bus.halted <= 1'b1;
            end
`endif
          end
        end
        default: begin
          if (bus.inst_ready) bus.inst_valid <= 1'b0;
          if (bus.redirect_valid) begin
            state <= RUN;
            pc <= bus.redirect_pc;
            bus.inst_valid <= 1'b0;
            bus.halted <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: randomized bench with a transaction-level reference model of loader, fetch stream, redirects and halt
module tb_imem_fetch_ctrl;
  localparam int AW = 6;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  imem_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  imem_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  int m_st;
  logic m_valid;
  logic [AW-1:0] m_pc, m_next, m_lptr;
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic drive(input bit lv, input logic [DW-1:0] ld, input bit dn, input bit rdy, input bit rv, input logic [AW-1:0] rp);
    bus.load_valid = lv;
    bus.load_data = ld;
    bus.load_done = dn;
    bus.inst_ready = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc = rp;
    #1;
  endtask

  task automatic tick;
    if (reset) begin
      m_st = 0; m_lptr = '0; m_next = '0; m_valid = 1'b0; m_pc = '0;
    end else if (m_st == 0) begin
      if (bus.load_valid) begin ref_mem[m_lptr] = bus.load_data; m_lptr = m_lptr + 1'b1; end
      if (bus.load_done) begin m_st = 1; m_next = '0; end
    end else if (bus.redirect_valid) begin
      m_st = 1; m_next = bus.redirect_pc; m_valid = 1'b0;
    end else if (m_st == 2) begin
      if (bus.inst_ready) m_valid = 1'b0;
    end else if (!m_valid || bus.inst_ready) begin
      m_valid = 1'b1; m_pc = m_next; m_next = m_next + 1'b1;
`ifdef FETCH_HALT_EN
      if (ref_mem[m_pc] == 16'hFFFF) m_st = 2;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(0, '0, 0, 0, 0, '0);
    tick;
    tick;
    drive(0, '0, 0, 0, 0, '0);
    n_cmp++; if (bus.loading !== 1'b1) begin n_fail++; $display("FAIL reset_loading: got %0b want 1", bus.loading); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b want 0", bus.halted); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.inst_valid); end
    n_cmp++; if (bus.inst_out !== '0 || bus.inst_pc !== '0) begin n_fail++; $display("FAIL reset_inst: out=%h pc=%0d want 0/0", bus.inst_out, bus.inst_pc); end
    n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem: we=%0b addr=%0d want 0/0", bus.mem_we, bus.mem_addr); end
    reset = 1'b0;
  endtask

  task automatic test_load_wrap_simul;
    logic [DW-1:0] w, last;
    last = '0;
    for (int i = 0; i < 65; i++) begin
      w = 16'($urandom_range(0, 32'hFFFE));
      last = w;
      drive(1, w, i == 64, 0, 0, '0);
      n_cmp++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'(i) || bus.mem_wdata !== w) begin
        n_fail++; $display("FAIL load_wrap[%0d]: we=%0b addr=%0d data=%h want we=1 addr=%0d data=%h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, i % 64, w);
      end
      tick;
    end
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++; if (bus.loading !== 1'b0) begin n_fail++; $display("FAIL simul_done_loading: got %0b want 0", bus.loading); end
    n_cmp++; if (bus.mem_addr !== '0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL first_run_cycle: addr=%0d valid=%0b want 0/0", bus.mem_addr, bus.inst_valid); end
    tick;
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== '0 || bus.inst_out !== last) begin n_fail++; $display("FAIL wrap_write_addr0: valid=%0b pc=%0d out=%h want 1/0/%h", bus.inst_valid, bus.inst_pc, bus.inst_out, last); end
    for (int c = 0; c < 6; c++) begin
      drive(0, '0, 0, 1, 0, '0);
      n_cmp++;
      if (bus.inst_valid !== m_valid || (m_valid && (bus.inst_pc !== m_pc || bus.inst_out !== ref_mem[m_pc]))) begin
        n_fail++; $display("FAIL post_load_stream: valid=%0b pc=%0d out=%h want valid=%0b pc=%0d out=%h", bus.inst_valid, bus.inst_pc, bus.inst_out, m_valid, m_pc, ref_mem[m_pc]);
      end
      tick;
    end
  endtask

  task automatic test_load_sweep;
    int k;
    reset = 1'b1;
    drive(0, '0, 0, 0, 0, '0);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'(16'h1000 + i), 0, 1, 1, 6'h15);
      n_cmp++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'(i) || bus.mem_wdata !== 16'(16'h1000 + i)) begin
        n_fail++; $display("FAIL load_sweep[%0d]: we=%0b addr=%0d data=%h want 1/%0d/%h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, i, 16'h1000 + i);
      end
      tick;
    end
    drive(0, '0, 1, 0, 0, '0);
    n_cmp++; if (bus.mem_we !== 1'b0 || bus.loading !== 1'b1) begin n_fail++; $display("FAIL load_idle: we=%0b loading=%0b want 0/1", bus.mem_we, bus.loading); end
    tick;
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++; if (bus.loading !== 1'b0 || bus.mem_addr !== '0) begin n_fail++; $display("FAIL sweep_enter_run: loading=%0b addr=%0d want 0/0", bus.loading, bus.mem_addr); end
    k = 0;
    for (int c = 0; c < 8; c++) begin
      drive(0, '0, 0, 1, 0, '0);
      n_cmp++;
      if (bus.inst_valid !== m_valid || (m_valid && (bus.inst_pc !== m_pc || bus.inst_out !== ref_mem[m_pc]))) begin
        n_fail++; $display("FAIL sweep_stream: valid=%0b pc=%0d out=%h want valid=%0b pc=%0d out=%h", bus.inst_valid, bus.inst_pc, bus.inst_out, m_valid, m_pc, ref_mem[m_pc]);
      end
      if (bus.inst_valid && k < 4) begin
        n_cmp++;
        if (bus.inst_out !== 16'(16'h1000 + k) || bus.inst_pc !== 6'(k)) begin n_fail++; $display("FAIL sweep_word[%0d]: out=%h pc=%0d want %h/%0d", k, bus.inst_out, bus.inst_pc, 16'h1000 + k, k); end
        k++;
      end
      tick;
    end
    n_cmp++; if (k != 4) begin n_fail++; $display("FAIL sweep_count: got %0d want 4", k); end
  endtask

  task automatic test_backpressure;
    for (int c = 0; c < 9; c++) begin
      drive(0, '0, 0, !(c >= 2 && c < 5), 0, '0);
      n_cmp++;
      if (bus.inst_valid !== m_valid || (m_valid && (bus.inst_pc !== m_pc || bus.inst_out !== ref_mem[m_pc]))) begin
        n_fail++; $display("FAIL backpressure_stream: valid=%0b pc=%0d out=%h want valid=%0b pc=%0d out=%h", bus.inst_valid, bus.inst_pc, bus.inst_out, m_valid, m_pc, ref_mem[m_pc]);
      end
      n_cmp++; if (bus.mem_addr !== m_next) begin n_fail++; $display("FAIL backpressure_pc: addr=%0d want %0d", bus.mem_addr, m_next); end
      tick;
    end
  endtask

  task automatic test_redirect;
    drive(0, '0, 0, 1, 1, 6'h20);
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== m_pc || bus.inst_out !== ref_mem[m_pc]) begin
      n_fail++; $display("FAIL redirect_consume: valid=%0b pc=%0d out=%h want 1/%0d/%h", bus.inst_valid, bus.inst_pc, bus.inst_out, m_pc, ref_mem[m_pc]);
    end
    tick;
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_bubble: valid=%0b want 0", bus.inst_valid); end
    tick;
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'h20 || bus.inst_out !== ref_mem[32]) begin
      n_fail++; $display("FAIL redirect_target: valid=%0b pc=%0d out=%h want 1/32/%h", bus.inst_valid, bus.inst_pc, bus.inst_out, ref_mem[32]);
    end
    tick;
  endtask

  task automatic test_wrap;
    logic [AW-1:0] want;
    int k;
    drive(0, '0, 0, 1, 1, 6'd62);
    tick;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      drive(0, '0, 0, 1, 0, '0);
      if (bus.inst_valid && k < 4) begin
        want = 6'(62 + k);
        n_cmp++;
        if (bus.inst_pc !== want || bus.inst_out !== ref_mem[want]) begin n_fail++; $display("FAIL wrap_order[%0d]: pc=%0d out=%h want %0d/%h", k, bus.inst_pc, bus.inst_out, want, ref_mem[want]); end
        k++;
      end
      tick;
    end
    n_cmp++; if (k != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", k); end
  endtask

  task automatic test_random;
    bit rdy, rv;
    for (int c = 0; c < 400; c++) begin
      rdy = $urandom_range(0, 3) != 0;
      rv = $urandom_range(0, 15) == 0;
      drive(0, '0, 0, rdy, rv, 6'($urandom));
      n_cmp++;
      if (bus.inst_valid !== m_valid || (m_valid && (bus.inst_pc !== m_pc || bus.inst_out !== ref_mem[m_pc])) || bus.mem_addr !== m_next || bus.mem_we !== 1'b0) begin
        n_fail++; $display("FAIL random[%0d]: valid=%0b pc=%0d out=%h addr=%0d we=%0b want valid=%0b pc=%0d out=%h addr=%0d we=0", c, bus.inst_valid, bus.inst_pc, bus.inst_out, bus.mem_addr, bus.mem_we, m_valid, m_pc, ref_mem[m_pc], m_next);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid_run;
    drive(0, '0, 0, 1, 0, '0);
    tick;
    reset = 1'b1;
    drive(0, '0, 0, 1, 0, '0);
    tick;
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++; if (bus.loading !== 1'b1 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_run: loading=%0b valid=%0b want 1/0", bus.loading, bus.inst_valid); end
    reset = 1'b0;
    drive(1, 16'h2222, 0, 0, 0, '0);
    n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== '0) begin n_fail++; $display("FAIL reload_addr0: we=%0b addr=%0d want 1/0", bus.mem_we, bus.mem_addr); end
    tick;
  endtask

  task automatic test_halt;
    reset = 1'b1;
    drive(0, '0, 0, 0, 0, '0);
    tick;
    reset = 1'b0;
    drive(1, 16'h1111, 0, 0, 0, '0);
    tick;
`ifdef FETCH_HALT_EN
    drive(1, 16'hFFFF, 1, 0, 0, '0);
    tick;
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_first: valid=%0b want 0", bus.inst_valid); end
    tick;
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== '0 || bus.inst_out !== 16'h1111 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_word0: valid=%0b pc=%0d out=%h halted=%0b want 1/0/1111/0", bus.inst_valid, bus.inst_pc, bus.inst_out, bus.halted); end
    tick;
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'd1 || bus.inst_out !== 16'hFFFF || bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_word1: valid=%0b pc=%0d out=%h halted=%0b want 1/1/ffff/1", bus.inst_valid, bus.inst_pc, bus.inst_out, bus.halted); end
    tick;
    for (int c = 0; c < 4; c++) begin
      drive(0, '0, 0, 1, 0, '0);
      n_cmp++; if (bus.inst_valid !== 1'b0 || bus.halted !== 1'b1 || bus.mem_addr !== 6'd2) begin n_fail++; $display("FAIL halt_hold[%0d]: valid=%0b halted=%0b addr=%0d want 0/1/2", c, bus.inst_valid, bus.halted, bus.mem_addr); end
      tick;
    end
    drive(0, '0, 0, 1, 1, '0);
    tick;
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++; if (bus.halted !== 1'b0 || bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_resume: halted=%0b valid=%0b want 0/0", bus.halted, bus.inst_valid); end
    tick;
    drive(0, '0, 0, 1, 0, '0);
    n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== '0 || bus.inst_out !== 16'h1111) begin n_fail++; $display("FAIL halt_refetch: valid=%0b pc=%0d out=%h want 1/0/1111", bus.inst_valid, bus.inst_pc, bus.inst_out); end
    tick;
`else
    drive(1, 16'hFFFF, 0, 0, 0, '0);
    tick;
    drive(1, 16'h2222, 1, 0, 0, '0);
    tick;
    drive(0, '0, 0, 1, 0, '0);
    tick;
    for (int c = 0; c < 3; c++) begin
      drive(0, '0, 0, 1, 0, '0);
      n_cmp++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 6'(c) || bus.halted !== 1'b0 || bus.inst_out !== (c == 0 ? 16'h1111 : c == 1 ? 16'hFFFF : 16'h2222)) begin
        n_fail++; $display("FAIL ones_ordinary[%0d]: valid=%0b pc=%0d out=%h halted=%0b", c, bus.inst_valid, bus.inst_pc, bus.inst_out, bus.halted);
      end
      tick;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_wrap_simul();
    test_load_sweep();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_mid_run();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
